// File: rtl/pri_enc_arbiter.sv
// N-input priority encoder with a registered valid/ready output stage.
// Define PRI_ENC_RR_EN for round-robin arbitration; fixed priority (highest index wins) otherwise.
module pri_enc_arbiter #(
    parameter  int unsigned N     = 8,
    localparam int unsigned IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     req,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [N-1:0]     out_grant,
    output logic             out_none
);

    localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(N - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N-1:0]     grant_q, grant_d;
    logic             none_q, none_d;

    logic             accept;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] win;
    logic             found;

    assign out_valid = (state_q == FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_idx   = idx_q;
    assign out_grant = grant_q;
    assign out_none  = none_q;

    // Downward search starting at ptr with wrap; ptr fixed at N-1 gives plain priority.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = IDX_W'((32'(ptr) + N - k) % N);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

`ifdef PRI_ENC_RR_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;

    // Next search starts just below the last winner.
    always_comb begin
        ptr_d = ptr_q;
        if (accept && found) begin
            ptr_d = (win == '0) ? PTR_RST : win - IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= PTR_RST;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = PTR_RST;
`endif

    // Output-stage next state: load on every accept, drain when consumer takes it.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        grant_d = grant_q;
        none_d  = none_q;
        case (state_q)
            EMPTY:   if (accept) state_d = FULL;
            FULL:    if (out_ready && !accept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
        if (accept) begin
            idx_d   = win;
            grant_d = found ? (N'(1) << win) : '0;
            none_d  = !found;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            idx_q   <= '0;
            grant_q <= '0;
            none_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            grant_q <= grant_d;
            none_q  <= none_d;
        end
    end

endmodule

// File: tb/tb_pri_enc_arbiter.sv
// Scoreboard bench for pri_enc_arbiter (N=8): driver pushes expected results, monitor pops on handshake.
module tb_pri_enc_arbiter;

    typedef struct packed {
        logic [2:0] idx;
        logic [7:0] grant;
        logic       none;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] req;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_idx;
    logic [7:0] out_grant;
    logic       out_none;

    exp_t       sb[$];
    int         n_chk  = 0;
    int         n_fail = 0;
    logic [2:0] tp     = 3'd7;

    pri_enc_arbiter #(.N(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .req       (req),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_grant (out_grant),
        .out_none  (out_none)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int unsigned act, input int unsigned expv);
        n_chk++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic exp_t mk(input int unsigned idx, input logic [7:0] g, input logic none);
        exp_t e;
        e.idx   = 3'(idx);
        e.grant = g;
        e.none  = none;
        return e;
    endfunction

    // Reference: rotate req so the current search start sits at bit 7, then take the top set bit.
    function automatic exp_t model(input logic [7:0] r);
        exp_t        e;
        logic [15:0] dbl;
        logic [7:0]  rot;
        e   = mk(0, 8'h00, 1'b1);
        dbl = {r, r};
        rot = 8'(dbl >> (int'(tp) + 1));
        for (int j = 7; j >= 0; j--) begin
            if (rot[j]) begin
                e.idx   = 3'((j + int'(tp) + 1) % 8);
                e.none  = 1'b0;
                e.grant = 8'(8'h01 << e.idx);
                break;
            end
        end
        return e;
    endfunction

    task automatic push_exp(input exp_t e);
        sb.push_back(e);
`ifdef PRI_ENC_RR_EN
        if (!e.none) tp = (e.idx == 3'd0) ? 3'd7 : e.idx - 3'd1;
`endif
    endtask

    // Enter and leave at posedge+1.
    task automatic send(input logic [7:0] r, input exp_t e);
        int unsigned cyc = 0;
        in_valid = 1'b1;
        req      = r;
        @(negedge clk);
        while (!in_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!in_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stuck 0 for req 0x%0h, want 1", r);
        end else begin
            push_exp(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned cyc = 0;
        while (sb.size() != 0 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results pending, want 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        sb.delete();
        tp = 3'd7;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: compare every handed-over result against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 32'(out_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_none", 32'(out_none), 32'(e.none));
                check("out_idx", 32'(out_idx), 32'(e.idx));
                check("out_grant", 32'(out_grant), 32'(e.grant));
            end
        end
    end

    logic [7:0] dv_req[8]   = '{8'b0010_1100, 8'h01, 8'h80, 8'h00, 8'h55, 8'h0A, 8'hFF, 8'h40};
    int         dv_idx[8]   = '{5, 0, 7, 0, 6, 3, 7, 6};
    logic [7:0] dv_grant[8] = '{8'h20, 8'h01, 8'h80, 8'h00, 8'h40, 8'h08, 8'h80, 8'h40};
    int         rr_seq[9]   = '{7, 6, 5, 4, 3, 2, 1, 0, 7};

    initial begin
        exp_t ea, eb;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        req       = 8'h00;
        out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_idx", 32'(out_idx), 32'd0);
        check("rst_out_grant", 32'(out_grant), 32'd0);
        check("rst_out_none", 32'(out_none), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

`ifdef PRI_ENC_RR_EN
        for (int i = 0; i < 9; i++)
            send(8'hFF, mk(rr_seq[i], 8'(8'h01 << rr_seq[i]), 1'b0));
`else
        for (int i = 0; i < 8; i++)
            send(dv_req[i], mk(dv_idx[i], dv_grant[i], dv_req[i] == 8'h00));
`endif
        drain();

        // Idle with garbage on req: nothing may come out.
        req = 8'bx1x0_x1x0;
        repeat (4) @(negedge clk);
        check("idle_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        apply_reset();
        for (int i = 0; i < 256; i++) begin
            send(8'(i), model(8'(i)));
            if (i % 16 == 15) begin
                @(posedge clk);
                #1;
            end
        end
        drain();

        // Backpressure: second request must wait until the consumer takes the first.
        out_ready = 1'b0;
        ea = model(8'h14);
        send(8'h14, ea);
        in_valid = 1'b1;
        req      = 8'h03;
        repeat (3) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_out_idx", 32'(out_idx), 32'(ea.idx));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", 32'(in_ready), 32'd1);
        eb = model(8'h03);
        push_exp(eb);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();

        // Async reset between edges while stalled.
        out_ready = 1'b0;
        send(8'h81, model(8'h81));
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("areset_out_valid", 32'(out_valid), 32'd0);
        check("areset_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        tp = 3'd7;
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(8'hFF, mk(7, 8'h80, 1'b0));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule
